data_bus_if: RTL and testbench

DATA_BUS_IF -- requirements
Module: data_bus_if

---
 rtl/data_bus_if.sv | 139 +++++++++++++
 tb/tb_data_bus_if.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_if.sv
// Memory-stage to Wishbone-style bus bridge; optional BUSY timeout under DBUS_TIMEOUT_EN.
// Latency: request edge plus ack cycle (2 min); backpressure: stallreq_o holds the pipe until ack.
module data_bus_if (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   input  logic        flush_i,
   input  logic        pipe_stall_i,
   output logic        stallreq_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [31:0] bus_adr_o,
   output logic [31:0] bus_dat_o,
   output logic [3:0]  bus_sel_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

   state_t      state, state_nxt;
   logic [31:0] rd_buf;
   logic        acc_we;
   logic        start, end_cyc, capture, tmo;

`ifdef DBUS_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Counter holds the number of earlier ack-less BUSY cycles; 254 means this is the 255th.
   always_ff @(posedge clk) begin
      if (rst || state != BUSY || bus_ack_i)
         tmo_cnt <= 8'd0;
      else
         tmo_cnt <= tmo_cnt + 8'd1;
   end

   assign tmo = (state == BUSY) && !bus_ack_i && !flush_i && (tmo_cnt == 8'd254);
`else
   assign tmo = 1'b0;
`endif

   assign bus_err_o = tmo & ~rst;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      stallreq_o = 1'b0;
      cpu_data_o = 32'd0;
      start      = 1'b0;
      end_cyc    = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               stallreq_o = 1'b1;
               start      = 1'b1;
               state_nxt  = BUSY;
            end
         end
         BUSY: begin
            if (flush_i) begin
               end_cyc   = 1'b1;
               state_nxt = IDLE;
            end else if (bus_ack_i) begin
               end_cyc = 1'b1;
               if (!acc_we) begin
                  cpu_data_o = bus_dat_i;
                  capture    = 1'b1;
               end
               state_nxt = pipe_stall_i ? WAIT_STALL : IDLE;
            end else if (tmo) begin
               end_cyc   = 1'b1;
               state_nxt = IDLE;
            end else begin
               stallreq_o = 1'b1;
            end
         end
         WAIT_STALL: begin
            if (flush_i) begin
               state_nxt = IDLE;
            end else begin
               // Writes never expose rd_buf, which still holds an older read.
               if (!acc_we)
                  cpu_data_o = rd_buf;
               if (!pipe_stall_i)
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         stallreq_o = 1'b0;
         cpu_data_o = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_cyc_o <= 1'b0;
         bus_stb_o <= 1'b0;
         bus_we_o  <= 1'b0;
         bus_adr_o <= 32'd0;
         bus_dat_o <= 32'd0;
         bus_sel_o <= 4'd0;
         acc_we    <= 1'b0;
         rd_buf    <= 32'd0;
      end else begin
         if (start) begin
            bus_cyc_o <= 1'b1;
            bus_stb_o <= 1'b1;
            bus_we_o  <= cpu_we_i;
            bus_adr_o <= cpu_addr_i;
            bus_dat_o <= cpu_data_i;
            bus_sel_o <= cpu_sel_i;
            acc_we    <= cpu_we_i;
         end else if (end_cyc) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
         end
         if (capture)
            rd_buf <= bus_dat_i;
      end
   end

endmodule

// File: tb/tb_data_bus_if.sv
// Scoreboarded bench for data_bus_if: driver acts as CPU and bus slave, monitor checks each ack.
module tb_data_bus_if;

   logic        clk, rst;
   logic        cpu_ce_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
   logic [3:0]  cpu_sel_i;
   logic        flush_i, pipe_stall_i, stallreq_o;
   logic        bus_cyc_o, bus_stb_o, bus_we_o;
   logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
   logic [3:0]  bus_sel_o;
   logic        bus_ack_i, bus_err_o;

   data_bus_if dut (
      .clk(clk), .rst(rst),
      .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .flush_i(flush_i), .pipe_stall_i(pipe_stall_i), .stallreq_o(stallreq_o),
      .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_sel_o(bus_sel_o),
      .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] cpu;
      logic        we;
      logic [3:0]  sel;
   } txn_t;

   txn_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted ack must match the oldest outstanding request.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus_cyc_o && bus_ack_i && !flush_i) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               txn_t t;
               t = sb.pop_front();
               chk("mon_adr", bus_adr_o, t.adr);
               chk("mon_we", 32'(bus_we_o), 32'(t.we));
               chk("mon_stb", 32'(bus_stb_o), 32'd1);
               chk("mon_sel", 32'(bus_sel_o), 32'(t.sel));
               if (t.we)
                  chk("mon_wdat", bus_dat_o, t.dat);
               chk("mon_cpu_data", cpu_data_o, t.cpu);
            end
         end
      end
   end

   // One complete access; stalls = number of WAIT_STALL cycles after the ack.
   task automatic access(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] rdata,
                         input int waits, input int stalls);
      txn_t t;
      t.adr = a; t.we = we; t.sel = s; t.dat = d;
      t.cpu = we ? 32'd0 : rdata;
      sb.push_back(t);
      cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_sel_i = s; cpu_data_i = d;
      #1;
      chk("req_stallreq", 32'(stallreq_o), 32'd1);
      chk("req_cyc_low", 32'(bus_cyc_o), 32'd0);
      @(negedge clk);
      cpu_ce_i = 1'b0; cpu_we_i = ~we;
      cpu_addr_i = $urandom; cpu_data_i = $urandom; cpu_sel_i = 4'($urandom);
      #1;
      chk("cyc_stb_up", 32'({bus_cyc_o, bus_stb_o}), 32'd3);
      for (int i = 0; i < waits; i++) begin
         #1;
         chk("wait_stallreq", 32'(stallreq_o), 32'd1);
         chk("wait_adr", bus_adr_o, a);
         chk("wait_sel", 32'(bus_sel_o), 32'(s));
         if (we) chk("wait_wdat", bus_dat_o, d);
         @(negedge clk);
      end
      bus_ack_i = 1'b1; bus_dat_i = rdata; pipe_stall_i = (stalls > 0);
      #1;
      chk("ack_stallreq", 32'(stallreq_o), 32'd0);
      @(negedge clk);
      bus_ack_i = 1'b0; bus_dat_i = $urandom;
      for (int i = 0; i < stalls; i++) begin
         pipe_stall_i = (i < stalls - 1);
         cpu_ce_i     = (i < stalls - 1);
         #1;
         chk("ws_cpu_data", cpu_data_o, t.cpu);
         chk("ws_stallreq", 32'(stallreq_o), 32'd0);
         chk("ws_no_cyc", 32'(bus_cyc_o), 32'd0);
         @(negedge clk);
      end
      pipe_stall_i = 1'b0; cpu_ce_i = 1'b0;
      #1;
      chk("idle_cyc", 32'({bus_cyc_o, bus_stb_o, bus_we_o}), 32'd0);
      chk("idle_cpu_data", cpu_data_o, 32'd0);
      chk("idle_stallreq", 32'(stallreq_o), 32'd0);
   endtask

   // Open a read cycle and leave it waiting in its first BUSY cycle.
   task automatic open_read(input logic [31:0] a);
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = a; cpu_sel_i = 4'hF;
      @(negedge clk);
      cpu_ce_i = 1'b0;
   endtask

   initial begin
      int          first_err, n_err, all_stall;
      logic [31:0] a;
      rst = 1'b1; cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h44;
      cpu_sel_i = 4'hF; cpu_data_i = 32'h0; flush_i = 1'b0; pipe_stall_i = 1'b0;
      bus_dat_i = 32'h0; bus_ack_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stallreq", 32'(stallreq_o), 32'd0);
      chk("rst_cyc", 32'({bus_cyc_o, bus_stb_o, bus_we_o}), 32'd0);
      chk("rst_adr", bus_adr_o, 32'd0);
      chk("rst_dat", bus_dat_o, 32'd0);
      chk("rst_sel", 32'(bus_sel_o), 32'd0);
      chk("rst_err", 32'(bus_err_o), 32'd0);
      chk("rst_cpu_data", cpu_data_o, 32'd0);
      cpu_ce_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1, 0);
      access(1'b1, 32'h0000_0020, 4'b1100, 32'h1234_5678, $urandom, 3, 0);
      access(1'b0, 32'h0000_0030, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 3);
      access(1'b1, 32'h0000_0040, 4'b0011, 32'h0000_A5A5, $urandom, 1, 2);

      // Flush in the second BUSY cycle together with an ack.
      @(negedge clk);
      open_read(32'h0000_0050);
      @(negedge clk);
      flush_i = 1'b1; bus_ack_i = 1'b1; bus_dat_i = 32'h5555_AAAA;
      #1;
      chk("flush_stallreq", 32'(stallreq_o), 32'd0);
      chk("flush_cpu_data", cpu_data_o, 32'd0);
      @(negedge clk);
      flush_i = 1'b0; bus_ack_i = 1'b0;
      #1;
      chk("flush_cyc_down", 32'({bus_cyc_o, bus_stb_o}), 32'd0);
      chk("flush_idle_data", cpu_data_o, 32'd0);

      // Ack while idle must be ignored.
      @(negedge clk);
      bus_ack_i = 1'b1; bus_dat_i = 32'h0BAD_0BAD;
      #1;
      chk("stray_ack_data", cpu_data_o, 32'd0);
      chk("stray_ack_stall", 32'(stallreq_o), 32'd0);
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("stray_ack_cyc", 32'(bus_cyc_o), 32'd0);

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         a = $urandom;
         access(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // Reset during BUSY with a simultaneous ack aborts the cycle.
      @(negedge clk);
      open_read(32'h0000_0060);
      rst = 1'b1; bus_ack_i = 1'b1; bus_dat_i = 32'h7777_7777;
      #1;
      chk("rstbusy_stallreq", 32'(stallreq_o), 32'd0);
      chk("rstbusy_cpu_data", cpu_data_o, 32'd0);
      @(negedge clk);
      rst = 1'b0; bus_ack_i = 1'b0;
      #1;
      chk("rstbusy_cyc", 32'({bus_cyc_o, bus_stb_o}), 32'd0);
      chk("rstbusy_adr", bus_adr_o, 32'd0);

      // Unanswered access.
      @(negedge clk);
      open_read(32'h0000_0070);
      first_err = -1; n_err = 0; all_stall = 1;
`ifdef DBUS_TIMEOUT_EN
      for (int k = 1; k <= 255; k++) begin
         #1;
         if (bus_err_o === 1'b1) begin
            n_err++;
            if (first_err < 0) first_err = k;
            chk("tmo_stallreq", 32'(stallreq_o), 32'd0);
            chk("tmo_cpu_data", cpu_data_o, 32'd0);
         end
         @(negedge clk);
      end
      #1;
      chk("tmo_err_cycle", 32'(first_err), 32'd255);
      chk("tmo_err_count", 32'(n_err), 32'd1);
      chk("tmo_cyc_down", 32'({bus_cyc_o, bus_stb_o}), 32'd0);
      chk("tmo_err_clear", 32'(bus_err_o), 32'd0);
`else
      for (int k = 1; k <= 300; k++) begin
         #1;
         if (bus_err_o !== 1'b0) n_err++;
         if (stallreq_o !== 1'b1) all_stall = 0;
         @(negedge clk);
      end
      #1;
      chk("notmo_stallreq", 32'(stallreq_o), 32'd1);
      chk("notmo_cyc", 32'(bus_cyc_o), 32'd1);
      chk("notmo_stall_all", 32'(all_stall), 32'd1);
      chk("notmo_err", 32'(n_err), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
